// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a run-time programmable PAT_W-bit pattern, optional
// non-overlapping mode and a saturating match counter. Define SEQDET_MASK_EN for per-bit compare masking.
module seq_pattern_detector #(
    parameter int                 PAT_W     = 3,
    parameter logic [PAT_W-1:0]   PAT_RESET = PAT_W'(3'b101),
    parameter int                 CNT_W     = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              x,
    input  logic              x_valid,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic              pat_load,
    input  logic              overlap_en,
    input  logic              cnt_clr,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0]  pat_mask_in,
`endif
    output logic              z,
    output logic              z_q,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [PAT_W-2:0]  hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic              z_q_q,   z_q_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [PAT_W-1:0]  window;
    logic              pat_eq;
    logic              match;

    // The window is the held history with the current bit appended as the newest (LSB).
    assign window = {hist_q, x};

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;

    assign pat_eq = (((window ^ pat_q) & mask_q) == '0);

    always_comb begin
        mask_d = mask_q;
        if (pat_load) begin
            mask_d = pat_mask_in;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign pat_eq = (window == pat_q);
`endif

    assign match = aresetn & x_valid & ~pat_load & (fill_q == FILL_MAX) & pat_eq;

    // A load flushes the history, so the new pattern must be seen in full from scratch.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            if (match && !overlap_en) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    always_comb begin
        z_q_d = match;
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
            z_q_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q_q  <= z_q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z         = match;
    assign z_q       = z_q_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == '1);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector (PAT_W=3, CNT_W=2 so saturation is reachable quickly).
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       pat_load = 1'b0;
    logic       overlap_en = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       z;
    logic       z_q;
    logic [1:0] match_cnt;
    logic       cnt_sat;
`ifdef SEQDET_MASK_EN
    logic [2:0] pat_mask_in = 3'b111;
`endif

    int checks = 0;
    int errors = 0;

    seq_pattern_detector #(
        .PAT_W    (3),
        .PAT_RESET(3'b101),
        .CNT_W    (2)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .x          (x),
        .x_valid    (x_valid),
        .pat_in     (pat_in),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .cnt_clr    (cnt_clr),
`ifdef SEQDET_MASK_EN
        .pat_mask_in(pat_mask_in),
`endif
        .z          (z),
        .z_q        (z_q),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, check Mealy z before the rising edge and z_q just after it.
    task automatic applyStimulus(input logic bitVal, input logic valid, input logic clr, input logic expZ);
        @(negedge clk);
        x        = bitVal;
        x_valid  = valid;
        cnt_clr  = clr;
        pat_load = 1'b0;
        #1;
        checkOutput("z", z, expZ);
        @(posedge clk);
        #1;
        checkOutput("z_q", z_q, expZ);
    endtask

    task automatic applyLoad(input logic [2:0] pat, input logic bitVal, input logic valid);
        @(negedge clk);
        pat_in   = pat;
        pat_load = 1'b1;
        x        = bitVal;
        x_valid  = valid;
        cnt_clr  = 1'b0;
        #1;
        checkOutput("z_on_load", z, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("z_q_on_load", z_q, 1'b0);
        @(negedge clk);
        pat_load = 1'b0;
        x_valid  = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        x        = 1'b0;
        x_valid  = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        aresetn  = 1'b0;
        #1;
        checkOutput("rst_z_q", z_q, 1'b0);
        checkOutput("rst_cnt", match_cnt, 2'd0);
        checkOutput("rst_sat", cnt_sat, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset defaults, with x_valid high during reset to prove z is held low.
        x       = 1'b1;
        x_valid = 1'b1;
        #2;
        checkOutput("rst_z_async", z, 1'b0);
        resetDut();

        // Overlapping: 1,0,1,0,1 matches on bits 3 and 5.
        overlap_en = 1'b1;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("ovl_cnt", match_cnt, 2'd2);
        checkOutput("ovl_sat", cnt_sat, 1'b0);

        // Non-overlapping: same stream, only bit 3 matches.
        resetDut();
        overlap_en = 1'b0;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("novl_cnt", match_cnt, 2'd1);

        // Gaps of 4 invalid cycles (x toggling) between valid bits 1,0,1.
        resetDut();
        overlap_en = 1'b1;
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(i[0], 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(~i[0], 0, 0, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("gap_cnt", match_cnt, 2'd1);

        // Reload to 110 while a bit that would complete 101 arrives; that bit is dropped.
        resetDut();
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyLoad(3'b110, 1'b1, 1'b1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("reload_cnt", match_cnt, 2'd1);

        // Saturation: five overlapping matches on a 2-bit counter stop at 3.
        resetDut();
        overlap_en = 1'b1;
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(1, 1, 0, 1);
        end
        checkOutput("sat_cnt", match_cnt, 2'd3);
        checkOutput("sat_flag", cnt_sat, 1'b1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("clr_vs_match_cnt", match_cnt, 2'd0);
        checkOutput("clr_vs_match_sat", cnt_sat, 1'b0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("post_clr_cnt", match_cnt, 2'd1);

        // Reset mid-stream after loading 110: partial bits lost and pattern back to 101.
        applyLoad(3'b110, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        x       = 1'b1;
        x_valid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_z", z, 1'b0);
        checkOutput("mid_rst_cnt", match_cnt, 2'd0);
        checkOutput("mid_rst_z_q", z_q, 1'b0);
        x_valid = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("mid_rst_pat_cnt", match_cnt, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised successor to the fixed serial "101" Mealy detector.
- Detects a run-time programmable PAT_W-bit pattern on a serial bit stream, qualified by a valid strobe.
- Overlapping or non-overlapping detection is selectable, and matches are counted in a saturating counter.
- Sits between the serial front-end and the status register block.

Parameters:
- PAT_W, 3, pattern length in bits (legal range 2..16).
- PAT_RESET, 3'b101 (width PAT_W), pattern register value after reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- aresetn  input  1  asynchronous active-low reset
- x  input  1  serial data bit
- x_valid  input  1  x is sampled this cycle
- pat_in  input  PAT_W  new pattern; MSB is the oldest bit
- pat_load  input  1  load pat_in into the pattern register
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_cnt
- z  output  1  combinational (Mealy) match pulse
- z_q  output  1  z registered one cycle later
- match_cnt  output  CNT_W  saturating count of matches
- cnt_sat  output  1  match_cnt is all-ones

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on aresetn, and all state uses it.
- Reset values: pattern register = PAT_RESET, hist = 0, fill = 0, z_q = 0, match_cnt = 0, cnt_sat = 0. With aresetn low, z = 0.
- State:
  - hist: (PAT_W-1)-bit shift register of the most recent valid bits.
  - fill: saturating counter, 0..PAT_W-1, of valid bits currently held in hist.
- Match (Mealy, same cycle):
  - z = x_valid & !pat_load & (fill == PAT_W-1) & ({hist, x} == pattern).
- Shift (x_valid=1, pat_load=0):
  - hist <= {hist[PAT_W-3:0], x}.
  - fill <= min(fill+1, PAT_W-1).
- Non-overlap (overlap_en=0) on a z cycle: fill <= 0 and hist <= 0, so the next match needs PAT_W fresh bits.
- Overlap (overlap_en=1): history is retained after a match. With PAT_W=3 and pattern 101 this is cycle-identical to the legacy detector.
- x_valid=0: hist and fill hold, z = 0.
- pat_load=1:
  - pattern <= pat_in, hist <= 0, fill <= 0.
  - A simultaneous x_valid bit is discarded and z = 0.
  - The new pattern applies from the next cycle.
- overlap_en is sampled every cycle and may change at any time. A change affects only the current cycle's post-match clear.
- z_q <= z.
- Counter:
  - cnt_clr=1: match_cnt <= 0. Clear wins over a same-cycle match.
  - Otherwise, on z with match_cnt != all-ones: match_cnt <= match_cnt + 1. At all-ones it holds.
  - cnt_sat = (match_cnt == {CNT_W{1'b1}}), combinational from the register.
- Reset mid-stream: everything returns to reset values immediately. A partially received pattern is lost.

Optional Feature:
- SEQDET_MASK_EN defined:
  - Adds port pat_mask_in (input, PAT_W), loaded with pat_load into a mask register (reset all-ones).
  - Match compares only bit positions where the mask is 1.
  - Mask all-zero matches any PAT_W valid bits.
- Undefined:
  - No port and no mask register; exact compare as above.

Test Plan:
- Reset default, overlap_en=1, valid stream 1,0,1,0,1 -> z high on bits 3 and 5, match_cnt=2, z_q follows z by one cycle.
- Same stream with overlap_en=0 -> z only on bit 3, match_cnt=1.
- Gaps: stream 1,0,1 with x_valid=0 for 4 cycles between bits -> single z on the third valid bit; z=0 during gaps.
- Pattern reload:
  - pat_load with pat_in=3'b110 during the stream, with x_valid=1 that cycle -> that bit is ignored.
  - Then 1,1,0 -> z on the third bit.
  - Old pattern 101 no longer matches.
- Saturation: CNT_W=2, 5 overlapping matches -> match_cnt stops at 3 with cnt_sat=1. cnt_clr coincident with a match -> match_cnt=0.
- Reset mid-stream: after 1,0, pulse aresetn low, then 1 -> no z. z_q=0, match_cnt=0, pattern = PAT_RESET.
